// File: rtl/axi4_lite_slave_wr_engine_pkg.sv
// Shared AXI4-Lite definitions for the slave write engine.
package axi4_lite_Defs;

  localparam int unsigned Addr_Width = 32;
  localparam int unsigned Data_Width = 32;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_t;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    RESP
  } wr_state_t;

endpackage

// File: rtl/axi4_lite_slave_wr_engine_skid_slot.sv
// One-entry valid/ready capture register. Ready is registered and held
// low through reset and until the first clock edge after reset release.
module axi4_lite_skid_slot #(
  parameter int unsigned Width = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [Width-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             clear,
  output logic             full,
  output logic [Width-1:0] data
);

  // Capture on handshake, hold until cleared; ready tracks the empty state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full     <= 1'b0;
      in_ready <= 1'b0;
      data     <= '0;
    end else if (clear) begin
      full     <= 1'b0;
      in_ready <= 1'b1;
    end else if (in_valid && in_ready) begin
      full     <= 1'b1;
      in_ready <= 1'b0;
      data     <= in_data;
    end else begin
      in_ready <= !full;
    end
  end

endmodule

// File: rtl/axi4_lite_slave_wr_engine.sv
// AXI4-Lite slave write engine: joins AW and W beats in either order,
// issues a single-cycle memory write and returns the B response.
module axi4_lite_slave_wr_engine #(
  parameter int unsigned Addr_Width = axi4_lite_Defs::Addr_Width,
  parameter int unsigned Data_Width = axi4_lite_Defs::Data_Width,
  parameter int unsigned Mem_Depth  = 4096
) (
  input  logic                         ACLK,
  input  logic                         ARESETN,
  input  logic [Addr_Width-1:0]        AWADDR,
  input  logic                         AWVALID,
  output logic                         AWREADY,
  input  logic [Data_Width-1:0]        WDATA,
  input  logic [Data_Width/8-1:0]      WSTRB,
  input  logic                         WVALID,
  output logic                         WREADY,
  output logic [1:0]                   BRESP,
  output logic                         BVALID,
  input  logic                         BREADY,
  output logic                         mem_we,
  output logic [$clog2(Mem_Depth)-1:0] mem_addr,
  output logic [Data_Width-1:0]        mem_wdata,
  output logic [Data_Width/8-1:0]      mem_wstrb
);

  import axi4_lite_Defs::*;

  localparam int unsigned Strb_Width = Data_Width / 8;
  localparam int unsigned Idx_Width  = $clog2(Mem_Depth);
  localparam int unsigned Word_Width = Addr_Width - 2;
  localparam logic [Word_Width-1:0] Depth_Word = Word_Width'(Mem_Depth);

  logic                             aw_full;
  logic                             w_full;
  logic                             b_hs;
  logic [Word_Width-1:0]            aw_word;
  logic [Word_Width-1:0]            aw_word_eff;
  logic [Data_Width+Strb_Width-1:0] w_bits;
  logic [Data_Width+Strb_Width-1:0] w_bits_eff;
  logic                             aw_have;
  logic                             w_have;
  logic                             in_range;
  logic                             resp_err;
  logic                             unused_addr_lsbs;
  wr_state_t                        state;

  // Byte offset within the word is not used: accesses are word aligned.
  assign unused_addr_lsbs = ^AWADDR[1:0];
  assign b_hs             = BVALID && BREADY;

  axi4_lite_skid_slot #(
    .Width (Word_Width)
  ) u_aw_slot (
    .clk      (ACLK),
    .rst_n    (ARESETN),
    .in_data  (AWADDR[Addr_Width-1:2]),
    .in_valid (AWVALID),
    .in_ready (AWREADY),
    .clear    (b_hs),
    .full     (aw_full),
    .data     (aw_word)
  );

  axi4_lite_skid_slot #(
    .Width (Data_Width + Strb_Width)
  ) u_w_slot (
    .clk      (ACLK),
    .rst_n    (ARESETN),
    .in_data  ({WSTRB, WDATA}),
    .in_valid (WVALID),
    .in_ready (WREADY),
    .clear    (b_hs),
    .full     (w_full),
    .data     (w_bits)
  );

  // A slot counts as present if already full or being filled on this edge,
  // so a same-edge handshake feeds the write stage directly from the bus.
  always_comb begin
    aw_have     = aw_full || (AWVALID && AWREADY);
    w_have      = w_full  || (WVALID  && WREADY);
    aw_word_eff = aw_full ? aw_word : AWADDR[Addr_Width-1:2];
    w_bits_eff  = w_full  ? w_bits  : {WSTRB, WDATA};
    in_range    = aw_word_eff < Depth_Word;
  end

  // Write FSM: join -> one-cycle memory write -> hold response until BREADY.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state     <= IDLE;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wstrb <= '0;
      BVALID    <= 1'b0;
      BRESP     <= OKAY;
      resp_err  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (aw_have && w_have) begin
            state     <= WRITE;
            mem_we    <= in_range;
            mem_addr  <= aw_word_eff[Idx_Width-1:0];
            mem_wdata <= w_bits_eff[Data_Width-1:0];
            mem_wstrb <= w_bits_eff[Data_Width+Strb_Width-1:Data_Width];
            resp_err  <= !in_range;
          end
        end
        WRITE: begin
          state  <= RESP;
          mem_we <= 1'b0;
          BVALID <= 1'b1;
          BRESP  <= resp_err ? SLVERR : OKAY;
        end
        RESP: begin
          if (BREADY) begin
            state  <= IDLE;
            BVALID <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          mem_we <= 1'b0;
          BVALID <= 1'b0;
        end
      endcase
    end
  end

endmodule
